// File: rtl/stickman_physics_if.sv
// Signal bundle between the game-state controller side (master) and the
// stickman vertical-motion engine (slave).
interface stickman_physics_if;
    // No valid/ready pair: frame_clk is a level strobe whose rising edge (seen in the
    // Clk domain) requests exactly one motion update; outputs are always valid registers.
    logic       frame_clk;
    logic [3:0] status;
    logic [9:0] GroundY;
    logic [7:0] keycode;
    logic [9:0] StickmanBottom;
    logic       Airborne;
    logic [1:0] JumpsLeft;
    logic [1:0] mstate_dbg;

    modport master (
        output frame_clk, status, GroundY, keycode,
        input  StickmanBottom, Airborne, JumpsLeft, mstate_dbg
    );

    modport slave (
        input  frame_clk, status, GroundY, keycode,
        output StickmanBottom, Airborne, JumpsLeft, mstate_dbg
    );
endinterface

// File: rtl/stickman_physics.sv
// Per-frame jump/gravity integrator producing the stickman's foot y-coordinate,
// with a double-jump budget refilled on landing.
module stickman_physics #(
    parameter int START_Y   = 400,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 15,
    parameter int Y_MAX     = 479,
    parameter int MAX_JUMPS = 2
) (
    input  logic Clk,
    input  logic Reset,
    stickman_physics_if.slave sif
);
    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } mstate_t;

    localparam logic        [9:0]  START_YV = 10'(START_Y);
    localparam logic signed [7:0]  JUMP_S   = 8'(JUMP_V);
    localparam logic signed [8:0]  GRAV_S   = 9'(GRAVITY);
    localparam logic signed [8:0]  MAXF_S   = 9'(MAX_FALL);
    localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);
    localparam logic        [9:0]  YMAX_U   = 10'(Y_MAX);
    localparam logic        [1:0]  JUMPS_V  = 2'(MAX_JUMPS);

    mstate_t            mstate, state_nxt;
    logic        [9:0]  y, y_nxt;
    logic signed [7:0]  vel, vel_nxt;
    logic        [1:0]  jumps, jumps_nxt;
    logic               jump_req, req_nxt;
    logic               fc_d;
    logic        [7:0]  key_d;

    logic               tick, press, waiting, motion, do_jump, gap, land;
    logic signed [7:0]  v_eff, vel_grav;
    logic signed [8:0]  v_grav;
    logic signed [10:0] y_new, gnd_s;

    always_comb begin
        tick     = sif.frame_clk & ~fc_d;
        press    = (sif.keycode == 8'h2c) & (key_d != 8'h2c);
        waiting  = sif.status[3];
        motion   = sif.status[2] & tick & ~waiting;
        do_jump  = jump_req & (jumps != 2'd0);
        v_eff    = do_jump ? -JUMP_S : vel;
        y_new    = $signed({1'b0, y}) + 11'(v_eff);
        gnd_s    = $signed({1'b0, sif.GroundY});
        gap      = sif.GroundY > y;
        land     = (v_eff > 8'sd0) && (sif.GroundY >= y) && (y_new >= gnd_s);
        v_grav   = 9'(v_eff) + GRAV_S;
        vel_grav = (v_grav > MAXF_S) ? MAXF_S[7:0] : v_grav[7:0];
        // A tick always consumes the request, and it can only exist during PLAY.
        req_nxt  = ~sif.status[2] ? 1'b0 : tick ? 1'b0 : press ? 1'b1 : jump_req;
    end

    always_comb begin
        y_nxt     = y;
        vel_nxt   = vel;
        jumps_nxt = jumps;
        if (waiting) begin
            y_nxt     = START_YV;
            vel_nxt   = 8'sd0;
            jumps_nxt = JUMPS_V;
        end else if (motion) begin
            if (do_jump)
                jumps_nxt = 2'(jumps - 2'd1);
            if (mstate == GROUNDED && !do_jump) begin
                if (gap)
                    vel_nxt = 8'sd0;
            end else if (land) begin
                y_nxt     = sif.GroundY;
                vel_nxt   = 8'sd0;
                jumps_nxt = JUMPS_V;
            end else if (y_new[10]) begin
                y_nxt   = 10'd0;
                vel_nxt = 8'sd0;
            end else begin
                y_nxt   = (y_new > YMAX_S) ? YMAX_U : y_new[9:0];
                vel_nxt = vel_grav;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            y        <= START_YV;
            vel      <= 8'sd0;
            jumps    <= JUMPS_V;
            jump_req <= 1'b0;
            fc_d     <= 1'b0;
            key_d    <= 8'h00;
        end else begin
            y        <= y_nxt;
            vel      <= vel_nxt;
            jumps    <= jumps_nxt;
            jump_req <= req_nxt;
            fc_d     <= sif.frame_clk;
            key_d    <= sif.keycode;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            mstate <= GROUNDED;
        else
            mstate <= state_nxt;
    end

    always_comb begin
        state_nxt = mstate;
        if (waiting) begin
            state_nxt = GROUNDED;
        end else if (motion) begin
            if (mstate == GROUNDED && !do_jump)
                state_nxt = gap ? FALLING : GROUNDED;
            else if (land)
                state_nxt = GROUNDED;
            else if (y_new[10])
                state_nxt = FALLING;
            else
                state_nxt = (vel_grav < 8'sd0) ? RISING : FALLING;
        end
    end

    always_comb begin
        sif.StickmanBottom = y;
        sif.Airborne       = (mstate != GROUNDED);
        sif.JumpsLeft      = jumps;
        sif.mstate_dbg     = mstate;
    end
endmodule

// File: tb/tb_stickman_physics.sv
// Randomized and directed bench for stickman_physics against an integer
// arithmetic model of the frame-by-frame jump/gravity rules.
module tb_stickman_physics;
    logic Clk = 1'b0;
    logic Reset;

    stickman_physics_if sif();

    stickman_physics dut (
        .Clk   (Clk),
        .Reset (Reset),
        .sif   (sif)
    );

    always #10 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: 0 = on ground, 1 = going up, 2 = going down.
    int         m_y, m_vel, m_state, m_jumps;
    bit         m_req, m_fc;
    logic [7:0] m_key;
    logic [12:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step();
        int  ve, yn;
        bit  tk, pr, jumped, rq;
        tk = sif.frame_clk && !m_fc;
        pr = (sif.keycode == 8'h2c) && (m_key != 8'h2c);
        if (Reset) begin
            m_y = 400; m_vel = 0; m_state = 0; m_jumps = 2;
            m_req = 0; m_fc = 0; m_key = 8'h00;
        end else begin
            rq = !sif.status[2] ? 1'b0 : tk ? 1'b0 : pr ? 1'b1 : m_req;
            if (sif.status[3]) begin
                m_y = 400; m_vel = 0; m_state = 0; m_jumps = 2;
            end else if (sif.status[2] && tk) begin
                jumped = m_req && (m_jumps > 0);
                if (jumped) begin
                    ve = -12;
                    m_jumps = m_jumps - 1;
                end else begin
                    ve = m_vel;
                end
                if (m_state == 0 && !jumped) begin
                    if (int'(sif.GroundY) > m_y) begin
                        m_state = 2;
                        m_vel = 0;
                    end
                end else begin
                    yn = m_y + ve;
                    if (ve > 0 && m_y <= int'(sif.GroundY) && yn >= int'(sif.GroundY)) begin
                        m_y = sif.GroundY; m_vel = 0; m_state = 0; m_jumps = 2;
                    end else if (yn < 0) begin
                        m_y = 0; m_vel = 0; m_state = 2;
                    end else begin
                        m_y = (yn > 479) ? 479 : yn;
                        m_vel = (ve + 1 > 15) ? 15 : ve + 1;
                        m_state = (m_vel < 0) ? 1 : 2;
                    end
                end
            end
            m_fc = sif.frame_clk;
            m_key = sif.keycode;
            m_req = rq;
        end
        exp_q.push_back({10'(m_y), (m_state != 0), 2'(m_jumps)});
    endfunction

    task automatic cyc();
        logic [12:0] e;
        @(posedge Clk);
        model_step();
        #1;
        e = exp_q.pop_front();
        check("bottom", sif.StickmanBottom, e[12:3]);
        check("airborne", sif.Airborne, e[2]);
        check("jumps", sif.JumpsLeft, e[1:0]);
    endtask

    task automatic tick();
        int w;
        w = $urandom_range(1, 3);
        sif.frame_clk = 1'b1;
        repeat (w) cyc();
        sif.frame_clk = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic press();
        sif.keycode = 8'h2c;
        cyc();
        sif.keycode = 8'h00;
        cyc();
    endtask

    task automatic to_wait_then_play();
        sif.status = 4'b1000;
        cyc();
        sif.status = 4'b0100;
        cyc();
    endtask

    initial begin
        int prev_y;
        int budget;
        Reset = 1'b1;
        sif.frame_clk = 1'b0;
        sif.status = 4'b1000;
        sif.GroundY = 10'd400;
        sif.keycode = 8'h00;
        repeat (2) cyc();
        Reset = 1'b0;
        cyc();
        check("reset_bottom", sif.StickmanBottom, 400);
        check("reset_airborne", sif.Airborne, 0);
        check("reset_jumps", sif.JumpsLeft, 2);

        repeat (10) tick();
        check("wait_bottom", sif.StickmanBottom, 400);

        // Space that starts the game must not jump.
        sif.keycode = 8'h2c;
        cyc();
        sif.status = 4'b0100;
        cyc();
        tick();
        check("start_press_bottom", sif.StickmanBottom, 400);
        check("start_press_airborne", sif.Airborne, 0);
        sif.keycode = 8'h00;
        cyc();

        press();
        tick();
        check("jump_t1", sif.StickmanBottom, 388);
        repeat (10) tick();
        tick();
        check("jump_t12_peak", sif.StickmanBottom, 322);
        repeat (13) tick();
        check("jump_t25_bottom", sif.StickmanBottom, 400);
        check("jump_t25_airborne", sif.Airborne, 0);
        check("jump_t25_jumps", sif.JumpsLeft, 2);

        press();
        repeat (3) tick();
        check("dbl_first", sif.JumpsLeft, 1);
        press();
        tick();
        check("dbl_second", sif.JumpsLeft, 0);
        press();
        tick();
        check("dbl_third", sif.JumpsLeft, 0);
        budget = 80;
        while (m_state != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("dbl_land_budget", budget > 0, 1);
        check("dbl_land_airborne", sif.Airborne, 0);
        check("dbl_land_jumps", sif.JumpsLeft, 2);

        sif.GroundY = 10'd600;
        repeat (30) tick();
        check("gap_clamp", sif.StickmanBottom, 479);
        check("gap_airborne", sif.Airborne, 1);
        to_wait_then_play();

        sif.GroundY = 10'd400;
        press();
        budget = 60;
        while (!(m_state == 2 && m_y >= 385) && budget > 0) begin
            tick();
            budget--;
        end
        check("wall_setup_budget", budget > 0, 1);
        sif.GroundY = 10'd380;
        prev_y = m_y;
        repeat (3) tick();
        check("wall_past_ground", sif.StickmanBottom > 10'(prev_y), 1);
        check("wall_airborne", sif.Airborne, 1);
        sif.GroundY = 10'd400;
        to_wait_then_play();

        press();
        repeat (4) tick();
        check("lose_pre", sif.StickmanBottom, 358);
        sif.status = 4'b0001;
        repeat (5) tick();
        check("lose_frozen", sif.StickmanBottom, 358);
        check("lose_airborne", sif.Airborne, 1);
        to_wait_then_play();

        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6: tick();
                7, 8, 9: press();
                10: begin
                    sif.keycode = 8'h2c;
                    sif.frame_clk = 1'b1;
                    cyc();
                    sif.keycode = 8'h00;
                    sif.frame_clk = 1'b0;
                    cyc();
                end
                11, 12: begin
                    case ($urandom_range(0, 5))
                        0: sif.GroundY = 10'd400;
                        1: sif.GroundY = 10'd380;
                        2: sif.GroundY = 10'd420;
                        3: sif.GroundY = 10'd479;
                        4: sif.GroundY = 10'd600;
                        default: sif.GroundY = 10'($urandom_range(250, 470));
                    endcase
                    cyc();
                end
                13: begin
                    case ($urandom_range(0, 7))
                        0: sif.status = 4'b1000;
                        1: sif.status = 4'b0010;
                        2: sif.status = 4'b0001;
                        3: sif.status = 4'b0000;
                        default: sif.status = 4'b0100;
                    endcase
                    cyc();
                end
                14: begin
                    sif.status = 4'b0100;
                    cyc();
                end
                15: begin
                    sif.keycode = 8'($urandom_range(0, 255));
                    cyc();
                end
                16: begin
                    if ($urandom_range(0, 9) == 0) begin
                        Reset = 1'b1;
                        cyc();
                        Reset = 1'b0;
                    end
                    cyc();
                end
                default: cyc();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
